// File: rtl/lfsr_pkg.sv
// Shared LFSR conventions for the PRBS generator and checker: state encoding,
// default polynomial and the next-bit function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

  localparam int                        LFSR_WIDTH_DEF = 8;
  localparam logic [LFSR_WIDTH_DEF-1:0] TAPS_DEF       = 8'hB8;
  localparam int                        LFSR_MAX_WIDTH = 32;

  // Callers zero-extend narrower registers up to LFSR_MAX_WIDTH.
  function automatic logic lfsr_next_bit(input logic [LFSR_MAX_WIDTH-1:0] state,
                                         input logic [LFSR_MAX_WIDTH-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Left-shifting LFSR register with selectable load source (received or
// predicted bit) and the predicted next bit; shared with the generator.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_DEF
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             shift_en,
  input  logic             use_pred,
  input  logic             rx_bit,
  output logic [WIDTH-1:0] state,
  output logic             pred
);

  logic [WIDTH-1:0] state_q;
  logic             load_bit;

  assign pred     = lfsr_next_bit(LFSR_MAX_WIDTH'(state_q), LFSR_MAX_WIDTH'(TAPS));
  assign load_bit = use_pred ? pred : rx_bit;
  assign state    = state_q;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= '0;
    end else if (shift_en) begin
      state_q <= {state_q[WIDTH-2:0], load_bit};
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS receiver: seeds from the stream, hunts for a run of
// correct predictions, then flywheels on its own LFSR and counts bit errors.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEED   | loading LFSR_WIDTH received bits into the shift register
//   ST_HUNT   | predicting from received bits, counting consecutive matches
//   ST_LOCKED | flywheel on predicted bits, flag and count mismatches
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = TAPS_DEF,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    ERR_LIMIT     = 4,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bitValid,
  input  logic                     i_bit,
  input  logic                     i_clearCnt,
  output logic                     o_locked,
  output logic                     o_error,
  output logic [ERR_CNT_WIDTH-1:0] o_errCount
);

  localparam int BIT_CNT_W = $clog2(LFSR_WIDTH + 1);
  localparam int RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam int TALLY_W   = $clog2(ERR_LIMIT + 1);

  localparam logic [BIT_CNT_W-1:0] SEED_LAST  = BIT_CNT_W'(LFSR_WIDTH - 1);
  localparam logic [RUN_W-1:0]     RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [TALLY_W-1:0]   TALLY_LAST = TALLY_W'(ERR_LIMIT - 1);

  lfsr_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RUN_W-1:0]         run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0]         good_run_q, good_run_d;
  logic [TALLY_W-1:0]       err_tally_q, err_tally_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     error_q, error_d;

  logic [LFSR_WIDTH-1:0]    lfsr_state;
  logic                     pred;
  logic                     mismatch;

  lfsr_core #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk_sys  (i_clk),
    .rst_b    (i_rst_n),
    .shift_en (i_bitValid),
    .use_pred (state_q == ST_LOCKED),
    .rx_bit   (i_bit),
    .state    (lfsr_state),
    .pred     (pred)
  );

  assign mismatch = (i_bit != pred);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_SEED;
      bit_cnt_q   <= '0;
      run_cnt_q   <= '0;
      good_run_q  <= '0;
      err_tally_q <= '0;
      err_cnt_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      run_cnt_q   <= run_cnt_d;
      good_run_q  <= good_run_d;
      err_tally_q <= err_tally_d;
      err_cnt_q   <= err_cnt_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    run_cnt_d   = run_cnt_q;
    good_run_d  = good_run_q;
    err_tally_d = err_tally_q;
    err_cnt_d   = err_cnt_q;
    error_d     = 1'b0;

    if (i_bitValid) begin
      case (state_q)
        ST_SEED: begin
          if (bit_cnt_q == SEED_LAST) begin
            bit_cnt_d = '0;
            run_cnt_d = '0;
            state_d   = ST_HUNT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        ST_HUNT: begin
          // An all-zero register predicts zeros forever; never lock on it.
          if (mismatch || (lfsr_state == '0)) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == RUN_LAST) begin
            run_cnt_d   = '0;
            good_run_d  = '0;
            err_tally_d = '0;
            state_d     = ST_LOCKED;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (mismatch) begin
            error_d    = 1'b1;
            good_run_d = '0;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_tally_q == TALLY_LAST) begin
              state_d     = ST_SEED;
              bit_cnt_d   = '0;
              run_cnt_d   = '0;
              err_tally_d = '0;
            end else begin
              err_tally_d = err_tally_q + 1'b1;
            end
          end else if (good_run_q == RUN_LAST) begin
            good_run_d  = '0;
            err_tally_d = '0;
          end else begin
            good_run_d = good_run_q + 1'b1;
          end
        end

        default: state_d = ST_SEED;
      endcase
    end

    if (i_clearCnt) begin
      err_cnt_d = '0;
    end
  end

  assign o_locked   = (state_q == ST_LOCKED);
  assign o_error    = error_q;
  assign o_errCount = err_cnt_q;

endmodule
